// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: core-side split-channel memory bus (command, read, write channels)
interface mem_port_ctrl_if #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS/8
);
  logic [p_ADDR_BITS-1:0] mem_addr;
  logic                   mem_cmd;
  logic [1:0]             mem_size;
  logic                   mem_valid;
  logic                   mem_ready;
  logic                   mem_r_valid;
  logic                   mem_r_ready;
  logic [p_DATA_BITS-1:0] mem_r_data;
  logic                   mem_r_resp;
  logic                   mem_w_valid;
  logic                   mem_w_ready;
  logic [p_STRB_BITS-1:0] mem_w_strb;
  logic [p_DATA_BITS-1:0] mem_w_data;
  logic                   mem_w_resp;
  modport master (
    output mem_addr, mem_cmd, mem_size, mem_valid, mem_r_ready, mem_w_valid, mem_w_strb, mem_w_data,
    input  mem_ready, mem_r_valid, mem_r_data, mem_r_resp, mem_w_ready, mem_w_resp
  );
  modport slave (
    input  mem_addr, mem_cmd, mem_size, mem_valid, mem_r_ready, mem_w_valid, mem_w_strb, mem_w_data,
    output mem_ready, mem_r_valid, mem_r_data, mem_r_resp, mem_w_ready, mem_w_resp
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: split-channel memory bus to synchronous SRAM port with in-order read response FIFO
module mem_port_ctrl #(
  parameter int p_ADDR_BITS  = 32,
  parameter int p_DATA_BITS  = 32,
  parameter int p_STRB_BITS  = p_DATA_BITS/8,
  parameter int p_RD_LATENCY = 1,
  parameter int p_RESP_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_port_ctrl_if.slave         bus,
  output logic [p_ADDR_BITS-1:0] addr,
  output logic                   rden,
  input  logic [p_DATA_BITS-1:0] rddata,
  output logic                   wren,
  output logic [p_STRB_BITS-1:0] wrstrb,
  output logic [p_DATA_BITS-1:0] wrdata
);
  localparam int OB = $clog2(p_STRB_BITS);
  localparam int PB = $clog2(p_RESP_DEPTH);
  typedef enum logic {IDLE, WDATA} state_t;
  state_t                 state;
  logic [PB:0]            outstanding, fifo_cnt;
  logic [PB-1:0]          rd_ptr, wr_ptr;
  logic [p_DATA_BITS-1:0] fifo_data [p_RESP_DEPTH];
  logic                   fifo_err [p_RESP_DEPTH];
  logic [p_RD_LATENCY-1:0] dl_v, dl_e;
  logic [p_ADDR_BITS-1:0] lat_addr, cmd_addr;
  logic [p_STRB_BITS-1:0] lat_mask, cmd_mask;
  logic [3:0]             nb;
  logic                   lat_err, cmd_err, rd_acc, wr_acc, w_hs, w_err, push, pop;
  assign nb       = 4'd1 << bus.mem_size;
  assign cmd_err  = |(bus.mem_addr[OB-1:0] & OB'(nb - 4'd1)) || int'(nb) > p_STRB_BITS;
  assign cmd_addr = {bus.mem_addr[p_ADDR_BITS-1:OB], {OB{1'b0}}};
  always_comb begin
    cmd_mask = '0;
    for (int i = 0; i < p_STRB_BITS; i++)
      cmd_mask[i] = i >= int'(bus.mem_addr[OB-1:0]) && i < int'(bus.mem_addr[OB-1:0]) + int'(nb);
  end
  assign bus.mem_ready   = rst && state == IDLE && outstanding < (PB+1)'(p_RESP_DEPTH);
  assign rd_acc          = bus.mem_valid && bus.mem_ready && !bus.mem_cmd;
  assign wr_acc          = bus.mem_valid && bus.mem_ready && bus.mem_cmd;
  assign bus.mem_w_ready = wr_acc || state == WDATA;
  assign w_hs            = bus.mem_w_valid && bus.mem_w_ready;
  assign w_err           = state == WDATA ? lat_err : cmd_err;
  assign rden            = rd_acc && !cmd_err;
  assign wren            = w_hs && !w_err;
  assign addr            = !rst ? '0 : state == WDATA ? lat_addr : cmd_addr;
  assign wrstrb          = wren ? bus.mem_w_strb & (state == WDATA ? lat_mask : cmd_mask) : '0;
  assign wrdata          = wren ? bus.mem_w_data : '0;
  assign push            = dl_v[p_RD_LATENCY-1];
  assign bus.mem_r_valid = fifo_cnt != '0;
  assign pop             = bus.mem_r_valid && bus.mem_r_ready;
  assign bus.mem_r_data  = bus.mem_r_valid ? fifo_data[rd_ptr] : '0;
  assign bus.mem_r_resp  = bus.mem_r_valid && fifo_err[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      outstanding    <= '0;
      fifo_cnt       <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      dl_v           <= '0;
      dl_e           <= '0;
      lat_addr       <= '0;
      lat_mask       <= '0;
      lat_err        <= 1'b0;
      bus.mem_w_resp <= 1'b0;
    end else begin
      state <= state == IDLE ? (wr_acc && !bus.mem_w_valid ? WDATA : IDLE) : (bus.mem_w_valid ? IDLE : WDATA);
      if (wr_acc) begin
        lat_addr <= cmd_addr;
        lat_mask <= cmd_mask;
        lat_err  <= cmd_err;
      end
      bus.mem_w_resp <= w_hs && w_err;
      outstanding    <= outstanding + (PB+1)'(rd_acc) - (PB+1)'(pop);
      fifo_cnt       <= fifo_cnt + (PB+1)'(push) - (PB+1)'(pop);
      rd_ptr         <= rd_ptr + PB'(pop);
      wr_ptr         <= wr_ptr + PB'(push);
      dl_v[0]        <= rd_acc;
      dl_e[0]        <= cmd_err;
      for (int i = 1; i < p_RD_LATENCY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_e[i] <= dl_e[i-1];
      end
    end
  end
  // error tokens carry zero data rather than whatever the array drove
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= dl_e[p_RD_LATENCY-1] ? '0 : rddata;
      fifo_err[wr_ptr]  <= dl_e[p_RD_LATENCY-1];
    end
  end
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed self-checking bench, read latency 2, response depth 4
module tb_mem_port_ctrl;
  logic        clk, rst;
  logic [31:0] addr, rddata, wrdata;
  logic        rden, wren;
  logic [3:0]  wrstrb;
  logic [31:0] arr [0:1023];
  logic [31:0] s1, s2;
  int          wcnt = 0;
  int          checks = 0;
  int          errors = 0;
  mem_port_ctrl_if #(.p_ADDR_BITS(32), .p_DATA_BITS(32)) bus ();
  mem_port_ctrl #(.p_ADDR_BITS(32), .p_DATA_BITS(32), .p_RD_LATENCY(2), .p_RESP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .addr(addr), .rden(rden), .rddata(rddata),
    .wren(wren), .wrstrb(wrstrb), .wrdata(wrdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // array model with two-cycle read latency
  always @(posedge clk) begin
    if (rden) s1 <= arr[addr[11:2]];
    s2 <= s1;
    if (wren) begin
      for (int b = 0; b < 4; b++) if (wrstrb[b]) arr[addr[11:2]][8*b+:8] <= wrdata[8*b+:8];
      wcnt <= wcnt + 1;
    end
  end
  assign rddata = s2;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d, input logic [3:0] s);
    bus.mem_valid = 1; bus.mem_cmd = 1; bus.mem_addr = a; bus.mem_size = sz;
    bus.mem_w_valid = 1; bus.mem_w_data = d; bus.mem_w_strb = s;
    cyc();
    bus.mem_valid = 0; bus.mem_w_valid = 0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic er, input logic [31:0] ed, input string tag);
    int n;
    bus.mem_valid = 1; bus.mem_cmd = 0; bus.mem_addr = a; bus.mem_size = sz; bus.mem_r_ready = 1;
    #1 chk({tag, "_rden"}, 64'(rden), 64'(!er));
    cyc();
    bus.mem_valid = 0;
    n = 0;
    while (!bus.mem_r_valid && n < 10) begin
      cyc();
      n++;
    end
    chk({tag, "_seen"}, 64'(bus.mem_r_valid), 64'(1));
    chk({tag, "_data"}, 64'(bus.mem_r_data), 64'(ed));
    chk({tag, "_resp"}, 64'(bus.mem_r_resp), 64'(er));
    cyc();
  endtask
  initial begin
    int got, sent, seen, wc0;
    logic acc;
    rst = 0;
    bus.mem_addr = 0; bus.mem_cmd = 0; bus.mem_size = 2; bus.mem_valid = 0; bus.mem_r_ready = 0;
    bus.mem_w_valid = 0; bus.mem_w_strb = 0; bus.mem_w_data = 0;
    repeat (2) cyc();
    bus.mem_valid = 1; bus.mem_addr = 32'h44;
    #1;
    chk("rst_ready", 64'(bus.mem_ready), 64'(0));
    chk("rst_rvalid", 64'(bus.mem_r_valid), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_rden", 64'(rden), 64'(0));
    bus.mem_valid = 0;
    rst = 1;
    #1 chk("rel_ready", 64'(bus.mem_ready), 64'(1));
    cyc();
    wr(32'h100, 2, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 6; i++) wr(32'(4*i), 2, 32'h1000 + 32'(i), 4'hF);
    // single read, latency 2: r_valid from the third cycle after accept
    bus.mem_valid = 1; bus.mem_cmd = 0; bus.mem_addr = 32'h100; bus.mem_size = 2; bus.mem_r_ready = 1;
    #1;
    chk("t1_rden", 64'(rden), 64'(1));
    chk("t1_addr", 64'(addr), 64'h100);
    cyc();
    bus.mem_valid = 0;
    #1 chk("t1_c1_rvalid", 64'(bus.mem_r_valid), 64'(0));
    cyc();
    #1 chk("t1_c2_rvalid", 64'(bus.mem_r_valid), 64'(0));
    cyc();
    #1;
    chk("t1_c3_rvalid", 64'(bus.mem_r_valid), 64'(1));
    chk("t1_data", 64'(bus.mem_r_data), 64'hDEADBEEF);
    chk("t1_resp", 64'(bus.mem_r_resp), 64'(0));
    cyc();
    #1 chk("t1_c4_rvalid", 64'(bus.mem_r_valid), 64'(0));
    cyc();
    // burst of six reads with responses held off
    bus.mem_r_ready = 0; bus.mem_valid = 1; bus.mem_cmd = 0; bus.mem_size = 2;
    for (int i = 0; i < 4; i++) begin
      bus.mem_addr = 32'(4*i);
      #1 chk("burst_ready", 64'(bus.mem_ready), 64'(1));
      cyc();
    end
    bus.mem_addr = 32'h10;
    #1;
    chk("full_ready", 64'(bus.mem_ready), 64'(0));
    chk("full_rden", 64'(rden), 64'(0));
    repeat (3) cyc();
    #1;
    chk("hold_rvalid", 64'(bus.mem_r_valid), 64'(1));
    chk("hold_data", 64'(bus.mem_r_data), 64'h1000);
    cyc();
    #1 chk("hold_stable", 64'(bus.mem_r_data), 64'h1000);
    bus.mem_r_ready = 1;
    #1 chk("pop_full_ready", 64'(bus.mem_ready), 64'(0));
    got = 0; sent = 4;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (bus.mem_r_valid) begin
        chk("burst_data", 64'(bus.mem_r_data), 64'(32'h1000 + 32'(got)));
        got++;
      end
      acc = bus.mem_valid && bus.mem_ready;
      cyc();
      if (acc) begin
        sent++;
        if (sent == 6) bus.mem_valid = 0;
        else bus.mem_addr = 32'(4*sent);
      end
      #1;
    end
    chk("burst_count", 64'(got), 64'(6));
    chk("burst_sent", 64'(sent), 64'(6));
    repeat (4) cyc();
    chk("burst_drained", 64'(bus.mem_r_valid), 64'(0));
    // byte write in the command cycle
    bus.mem_valid = 1; bus.mem_cmd = 1; bus.mem_addr = 32'h103; bus.mem_size = 0;
    bus.mem_w_valid = 1; bus.mem_w_data = 32'hAABBCCDD; bus.mem_w_strb = 4'hF;
    #1;
    chk("t3_wren", 64'(wren), 64'(1));
    chk("t3_wrstrb", 64'(wrstrb), 64'h8);
    chk("t3_addr", 64'(addr), 64'h100);
    chk("t3_wrdata", 64'(wrdata), 64'hAABBCCDD);
    cyc();
    bus.mem_valid = 0; bus.mem_w_valid = 0;
    #1 chk("t3_wresp", 64'(bus.mem_w_resp), 64'(0));
    cyc();
    rd(32'h100, 2, 0, 32'hAAADBEEF, "t3_rb");
    // deferred write data
    wc0 = wcnt;
    bus.mem_valid = 1; bus.mem_cmd = 1; bus.mem_addr = 32'h200; bus.mem_size = 2; bus.mem_w_valid = 0;
    #1;
    chk("t4_wready", 64'(bus.mem_w_ready), 64'(1));
    chk("t4_c0_wren", 64'(wren), 64'(0));
    cyc();
    bus.mem_valid = 0; bus.mem_addr = 32'h300;
    #1;
    chk("t4_c1_ready", 64'(bus.mem_ready), 64'(0));
    chk("t4_c1_wready", 64'(bus.mem_w_ready), 64'(1));
    chk("t4_c1_wren", 64'(wren), 64'(0));
    cyc();
    #1 chk("t4_c2_ready", 64'(bus.mem_ready), 64'(0));
    cyc();
    bus.mem_w_valid = 1; bus.mem_w_data = 32'h12345678; bus.mem_w_strb = 4'hF;
    #1;
    chk("t4_wren", 64'(wren), 64'(1));
    chk("t4_addr", 64'(addr), 64'h200);
    chk("t4_wrstrb", 64'(wrstrb), 64'hF);
    cyc();
    bus.mem_w_valid = 0;
    #1;
    chk("t4_ready_back", 64'(bus.mem_ready), 64'(1));
    chk("t4_wren_count", 64'(wcnt - wc0), 64'(1));
    rd(32'h200, 2, 0, 32'h12345678, "t4_rb");
    // illegal accesses
    rd(32'h102, 2, 1, 32'h0, "mis_rd");
    rd(32'h0, 3, 1, 32'h0, "sz3_rd");
    bus.mem_valid = 1; bus.mem_cmd = 1; bus.mem_addr = 32'h101; bus.mem_size = 1;
    bus.mem_w_valid = 1; bus.mem_w_data = 32'h55667788; bus.mem_w_strb = 4'h3;
    #1;
    chk("mis_wren", 64'(wren), 64'(0));
    chk("mis_wready", 64'(bus.mem_w_ready), 64'(1));
    cyc();
    bus.mem_valid = 0; bus.mem_w_valid = 0;
    #1 chk("mis_wresp", 64'(bus.mem_w_resp), 64'(1));
    cyc();
    #1 chk("mis_wresp_end", 64'(bus.mem_w_resp), 64'(0));
    rd(32'h100, 2, 0, 32'hAAADBEEF, "mis_rb");
    // reset with reads in flight
    bus.mem_r_ready = 0; bus.mem_cmd = 0; bus.mem_size = 2; bus.mem_valid = 1; bus.mem_addr = 32'h0;
    cyc();
    bus.mem_addr = 32'h4;
    cyc();
    bus.mem_addr = 32'h8; bus.mem_w_valid = 1; bus.mem_w_strb = 4'hF; bus.mem_w_data = 32'hCAFEF00D;
    rst = 0;
    #1;
    chk("mid_ready", 64'(bus.mem_ready), 64'(0));
    chk("mid_rvalid", 64'(bus.mem_r_valid), 64'(0));
    chk("mid_rdata", 64'(bus.mem_r_data), 64'(0));
    chk("mid_rresp", 64'(bus.mem_r_resp), 64'(0));
    chk("mid_wready", 64'(bus.mem_w_ready), 64'(0));
    chk("mid_wresp", 64'(bus.mem_w_resp), 64'(0));
    chk("mid_rden", 64'(rden), 64'(0));
    chk("mid_wren", 64'(wren), 64'(0));
    chk("mid_addr", 64'(addr), 64'(0));
    chk("mid_wrstrb", 64'(wrstrb), 64'(0));
    chk("mid_wrdata", 64'(wrdata), 64'(0));
    cyc();
    rst = 1; bus.mem_valid = 0; bus.mem_w_valid = 0; bus.mem_r_ready = 1;
    seen = 0;
    repeat (8) begin
      #1;
      if (bus.mem_r_valid) seen++;
      cyc();
    end
    chk("no_stale", 64'(seen), 64'(0));
    chk("post_ready", 64'(bus.mem_ready), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
